grid_reader: RTL

Reads the 28x28 one-bit drawing canvas back out of pixel memory after the user finishes drawing. Streams it in raster order as 8-bit intensity samples over a valid/ready handshake to the inference datapath. While streaming, it accumulates the set-pixel count and a bounding box, both reported at completion. It sits between the canvas memory read port and the network input buffer; it is the read side of the canvas writer.

---
 rtl/grid_reader.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/grid_reader.sv
`default_nettype none
// ============================================================================
//  Module   : grid_reader
//  Purpose  : Streams the 28x28 one-bit canvas out in raster order as 8-bit
//             samples and accumulates set-pixel count and bounding box.
//  Revision : 1.0
// ============================================================================
module grid_reader #(
   parameter int         GRID_SIZE = 28,
   parameter logic [7:0] ON_VALUE  = 8'd255,
   parameter logic [7:0] OFF_VALUE = 8'd0
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       mem_rd_en,
   output logic [9:0] mem_addr,
   input  logic       mem_rdata,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [4:0] out_x,
   output logic [4:0] out_y,
   output logic       out_last,
   output logic       done,
   output logic [9:0] pix_count,
   output logic [4:0] bbox_min_x,
   output logic [4:0] bbox_max_x,
   output logic [4:0] bbox_min_y,
   output logic [4:0] bbox_max_y,
   output logic       empty
);

   localparam logic [9:0] LAST_ADDR = 10'(GRID_SIZE * GRID_SIZE - 1);
   localparam logic [4:0] LAST_XY   = 5'(GRID_SIZE - 1);
   localparam logic [4:0] MIN_INIT  = 5'd31;
   localparam logic [4:0] MAX_INIT  = 5'd0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [9:0] addr_q, addr_d;
   logic [4:0] x_q, x_d;
   logic [4:0] y_q, y_d;

   logic       infl_q;
   logic [4:0] infl_x_q, infl_y_q;
   logic       infl_last_q;

   logic       fifo_bit_q  [2];
   logic [4:0] fifo_x_q    [2];
   logic [4:0] fifo_y_q    [2];
   logic       fifo_last_q [2];
   logic       rd_ptr_q, rd_ptr_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic [1:0] cnt_q, cnt_d;

   logic [9:0] pix_q, pix_d;
   logic [4:0] min_x_q, min_x_d, max_x_q, max_x_d;
   logic [4:0] min_y_q, min_y_d, max_y_q, max_y_d;
   logic       empty_q, empty_d;

   logic       w_valid;
   logic       w_pop;
   logic       w_push;
   logic [1:0] w_occ;
   logic       w_rd_en;
   logic       w_head_bit;
   logic [4:0] w_head_x, w_head_y;
   logic       w_head_last;
   logic       w_start;

   assign w_valid     = (cnt_q != 2'd0);
   assign w_pop       = w_valid && out_ready;
   assign w_push      = infl_q;
   assign w_head_bit  = fifo_bit_q[rd_ptr_q];
   assign w_head_x    = fifo_x_q[rd_ptr_q];
   assign w_head_y    = fifo_y_q[rd_ptr_q];
   assign w_head_last = fifo_last_q[rd_ptr_q];
   assign w_start     = (state_q == S_IDLE) && start;

   // Occupancy seen by the issue logic already discounts a head leaving this
   // cycle, which is what sustains one sample per cycle without overflow.
   assign w_occ   = cnt_q - {1'b0, w_pop};
   assign w_rd_en = (state_q == S_READ) && ((w_occ + {1'b0, infl_q}) < 2'd2);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      x_d     = x_q;
      y_d     = y_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_READ;
               addr_d  = 10'd0;
               x_d     = 5'd0;
               y_d     = 5'd0;
            end
         end
         S_READ: begin
            if (w_rd_en) begin
               addr_d = addr_q + 10'd1;
               if (x_q == LAST_XY) begin
                  x_d = 5'd0;
                  y_d = y_q + 5'd1;
               end else begin
                  x_d = x_q + 5'd1;
               end
               if (addr_q == LAST_ADDR) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (w_pop && w_head_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q ^ w_pop;
      wr_ptr_d = wr_ptr_q ^ w_push;
      cnt_d    = cnt_q + {1'b0, w_push} - {1'b0, w_pop};
   end

   always_comb begin
      pix_d   = pix_q;
      min_x_d = min_x_q;
      max_x_d = max_x_q;
      min_y_d = min_y_q;
      max_y_d = max_y_q;
      empty_d = empty_q;
      if (w_start) begin
         pix_d   = 10'd0;
         min_x_d = MIN_INIT;
         max_x_d = MAX_INIT;
         min_y_d = MIN_INIT;
         max_y_d = MAX_INIT;
         empty_d = 1'b0;
      end else if (w_pop) begin
         if (w_head_bit) begin
            pix_d = pix_q + 10'd1;
            if (w_head_x < min_x_q) min_x_d = w_head_x;
            if (w_head_x > max_x_q) max_x_d = w_head_x;
            if (w_head_y < min_y_q) min_y_d = w_head_y;
            if (w_head_y > max_y_q) max_y_d = w_head_y;
         end
         // Resolved on the final transfer so empty is valid during DONE.
         if (w_head_last) begin
            empty_d = (pix_d == 10'd0);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= 10'd0;
         x_q         <= 5'd0;
         y_q         <= 5'd0;
         infl_q      <= 1'b0;
         infl_x_q    <= 5'd0;
         infl_y_q    <= 5'd0;
         infl_last_q <= 1'b0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         cnt_q       <= 2'd0;
         pix_q       <= 10'd0;
         min_x_q     <= MIN_INIT;
         max_x_q     <= MAX_INIT;
         min_y_q     <= MIN_INIT;
         max_y_q     <= MAX_INIT;
         empty_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         x_q         <= x_d;
         y_q         <= y_d;
         infl_q      <= w_rd_en;
         if (w_rd_en) begin
            infl_x_q    <= x_q;
            infl_y_q    <= y_q;
            infl_last_q <= (addr_q == LAST_ADDR);
         end
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         pix_q       <= pix_d;
         min_x_q     <= min_x_d;
         max_x_q     <= max_x_d;
         min_y_q     <= min_y_d;
         max_y_q     <= max_y_d;
         empty_q     <= empty_d;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            fifo_bit_q[i]  <= 1'b0;
            fifo_x_q[i]    <= 5'd0;
            fifo_y_q[i]    <= 5'd0;
            fifo_last_q[i] <= 1'b0;
         end
      end else if (w_push) begin
         fifo_bit_q[wr_ptr_q]  <= mem_rdata;
         fifo_x_q[wr_ptr_q]    <= infl_x_q;
         fifo_y_q[wr_ptr_q]    <= infl_y_q;
         fifo_last_q[wr_ptr_q] <= infl_last_q;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign mem_rd_en  = w_rd_en;
   assign mem_addr   = addr_q;
   assign out_valid  = w_valid;
   assign out_data   = w_valid ? (w_head_bit ? ON_VALUE : OFF_VALUE) : 8'd0;
   assign out_x      = w_valid ? w_head_x : 5'd0;
   assign out_y      = w_valid ? w_head_y : 5'd0;
   assign out_last   = w_valid && w_head_last;
   assign pix_count  = pix_q;
   assign bbox_min_x = min_x_q;
   assign bbox_max_x = max_x_q;
   assign bbox_min_y = min_y_q;
   assign bbox_max_y = max_y_q;
   assign empty      = empty_q;

endmodule
`default_nettype wire
